// File: rtl/rbfu_wb.sv
// rtl/rbfu_wb.sv - RBFU write-back aligner: latency delay line + output FIFO; optional check RBFU_WB_RANGE_CHK_EN
module rbfu_wb #(
  parameter int ADDR_W     = 8,
  parameter int DATA_WIDTH = 12,
  parameter int LAT_R2     = 2,
  parameter int LAT_R4     = 3,
  parameter int LAT_PWM    = 3,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [1:0]            iss_opcode,
  input  logic                  iss_radix,
  input  logic [ADDR_W-1:0]     iss_addr0,
  input  logic [ADDR_W-1:0]     iss_addr1,
  input  logic [ADDR_W-1:0]     iss_addr2,
  input  logic [ADDR_W-1:0]     iss_addr3,
  input  logic [DATA_WIDTH-1:0] rbfu_d0,
  input  logic [DATA_WIDTH-1:0] rbfu_d1,
  input  logic [DATA_WIDTH-1:0] rbfu_d2,
  input  logic [DATA_WIDTH-1:0] rbfu_d3,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data0,
  output logic [DATA_WIDTH-1:0] wb_data1,
  output logic [DATA_WIDTH-1:0] wb_data2,
  output logic [DATA_WIDTH-1:0] wb_data3,
  output logic [ADDR_W-1:0]     wb_addr0,
  output logic [ADDR_W-1:0]     wb_addr1,
  output logic [ADDR_W-1:0]     wb_addr2,
  output logic [ADDR_W-1:0]     wb_addr3,
  output logic [3:0]            wb_mask,
  output logic                  busy,
  output logic                  range_err
);
  localparam int MAXL_A = (LAT_R4 > LAT_PWM) ? LAT_R4 : LAT_PWM;
  localparam int MAXL   = (LAT_R2 > MAXL_A) ? LAT_R2 : MAXL_A;
  localparam int LW     = $clog2(MAXL + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef struct packed {
    logic                   valid;
    logic [3:0]             mask;
    logic [3:0][ADDR_W-1:0] addr;
  } dl_t;

  typedef struct packed {
    logic [3:0]                 mask;
    logic [3:0][ADDR_W-1:0]     addr;
    logic [3:0][DATA_WIDTH-1:0] data;
  } ent_t;

  dl_t                        dl [MAXL];
  ent_t                       mem [DEPTH];
  ent_t                       head;
  ent_t                       push_ent;
  dl_t                        new_dl;
  logic [PW-1:0]              wptr, rptr;
  logic [CW-1:0]              inflight, fifo_count;
  logic [LW-1:0]              last_lat, lat_in;
  logic [3:0][DATA_WIDTH-1:0] d_in;
  logic                       is_pwm, is_nop, mode_block, credit_ok;
  logic                       accept, new_entry, arrive, pop;

  assign d_in = {rbfu_d3, rbfu_d2, rbfu_d1, rbfu_d0};

  // Decode the issue request: latency class, entry contents and admission.
  always_comb begin
    is_pwm = (iss_opcode == 2'b10) && iss_radix;
    is_nop = (iss_opcode == 2'b11) || ((iss_opcode == 2'b10) && !iss_radix);
    if (!iss_radix)                lat_in = LW'(LAT_R2);
    else if (iss_opcode == 2'b10)  lat_in = LW'(LAT_PWM);
    else                           lat_in = LW'(LAT_R4);
    // A different latency while anything is in flight could land two entries on one tap.
    mode_block   = (inflight != '0) && (lat_in != last_lat);
    credit_ok    = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
    iss_ready    = rst_n && credit_ok && !mode_block;
    accept       = iss_valid && iss_ready;
    new_entry    = accept && !is_nop;
    new_dl.valid = 1'b1;
    new_dl.mask  = is_pwm ? 4'b0011 : 4'b1111;
    new_dl.addr  = {is_pwm ? '0 : iss_addr3, is_pwm ? '0 : iss_addr2, iss_addr1, iss_addr0};
    arrive       = dl[0].valid;
    pop          = wb_valid && wb_ready;
  end

  // Build the FIFO word from the tap-0 entry and the RBFU lanes; masked-off lanes read as 0.
  always_comb begin
    push_ent.mask = dl[0].mask;
    push_ent.addr = dl[0].addr;
    for (int i = 0; i < 4; i++) push_ent.data[i] = dl[0].mask[i] ? d_in[i] : '0;
  end

  // Delay line: shift toward tap 0, inject a new entry at tap L-1 so it exits after L edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXL; i++) dl[i] <= '0;
    end else begin
      for (int i = 0; i < MAXL - 1; i++) dl[i] <= dl[i + 1];
      dl[MAXL-1] <= '0;
      if (new_entry) dl[lat_in - 1'b1] <= new_dl;
    end
  end

  // Occupancy counters, FIFO pointers and the latency of the last accepted entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= '0;
      fifo_count <= '0;
      wptr       <= '0;
      rptr       <= '0;
      last_lat   <= '0;
    end else begin
      inflight   <= inflight + CW'(new_entry) - CW'(arrive);
      fifo_count <= fifo_count + CW'(arrive) - CW'(pop);
      if (arrive)    wptr     <= wptr + 1'b1;
      if (pop)       rptr     <= rptr + 1'b1;
      if (new_entry) last_lat <= lat_in;
    end
  end

  // FIFO storage; stale contents are never visible because outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (arrive) mem[wptr] <= push_ent;
  end

  // Present the FIFO head, forced to zero when empty.
  always_comb begin
    head     = mem[rptr];
    wb_valid = (fifo_count != '0);
    wb_data0 = wb_valid ? head.data[0] : '0;
    wb_data1 = wb_valid ? head.data[1] : '0;
    wb_data2 = wb_valid ? head.data[2] : '0;
    wb_data3 = wb_valid ? head.data[3] : '0;
    wb_addr0 = wb_valid ? head.addr[0] : '0;
    wb_addr1 = wb_valid ? head.addr[1] : '0;
    wb_addr2 = wb_valid ? head.addr[2] : '0;
    wb_addr3 = wb_valid ? head.addr[3] : '0;
    wb_mask  = wb_valid ? head.mask    : '0;
    busy     = (inflight != '0) || wb_valid;
  end

`ifdef RBFU_WB_RANGE_CHK_EN
  localparam logic [DATA_WIDTH-1:0] Q_MOD = DATA_WIDTH'(3329);
  logic range_hit;

  // Any written lane holding a value outside [0, q) on this push.
  always_comb begin
    range_hit = 1'b0;
    for (int i = 0; i < 4; i++) if (dl[0].mask[i] && (d_in[i] >= Q_MOD)) range_hit = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   range_err <= 1'b0;
    else if (arrive && range_hit) range_err <= 1'b1;
  end
`else
  assign range_err = 1'b0;
`endif

endmodule
